// File: rtl/sram_ctrl.sv
// Bus-side controller for a 512K x 8 asynchronous SRAM: splits byte/halfword/word
// requests into sequential byte accesses with programmable read and write-pulse wait states.
module sram_ctrl #(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        we,
    input  logic [18:0] addr,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        resp,
    output logic [31:0] rdata,
    output logic        sram_ce_bar,
    output logic        sram_oe_bar,
    output logic        sram_we_bar,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_data_o,
    output logic        sram_data_t,
    input  logic [7:0]  sram_data_i
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    logic [2:0]       state_reg, state_next;
    logic [1:0]       idx_reg, idx_next;
    logic [1:0]       last_reg, last_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [18:0]      base_reg, base_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic             accept;
    logic             sample;

    logic        ready_reg;
    logic        resp_reg;
    logic [31:0] rdata_reg;
    logic        ce_bar_reg;
    logic        oe_bar_reg;
    logic        we_bar_reg;
    logic [18:0] sram_addr_reg;
    logic [7:0]  sram_data_o_reg;
    logic        sram_data_t_reg;

    logic next_is_rd;
    logic next_is_wr;

    // Size code 3 behaves like a word access.
    function automatic logic [1:0] last_index(input logic [1:0] sz);
        case (sz)
            2'd0:    last_index = 2'd0;
            2'd1:    last_index = 2'd1;
            default: last_index = 2'd3;
        endcase
    endfunction

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        sample     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req && ready_reg) begin
                    accept   = 1'b1;
                    idx_next = 2'd0;
                    if (we) begin
                        state_next = S_WR_SETUP;
                        cnt_next   = '0;
                    end else begin
                        state_next = S_RD;
                        cnt_next   = RD_LOAD;
                    end
                end
            end
            S_RD: begin
                if (cnt_reg == '0) begin
                    sample = 1'b1;
                    if (idx_reg == last_reg) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next = idx_reg + 2'd1;
                        cnt_next = RD_LOAD;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_WR_SETUP: begin
                state_next = S_WR_PULSE;
                cnt_next   = WR_LOAD;
            end
            S_WR_PULSE: begin
                if (cnt_reg == '0) begin
                    state_next = S_WR_HOLD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_WR_HOLD: begin
                if (idx_reg == last_reg) begin
                    state_next = S_DONE;
                end else begin
                    idx_next   = idx_reg + 2'd1;
                    state_next = S_WR_SETUP;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign base_next  = accept ? addr  : base_reg;
    assign last_next  = accept ? last_index(size) : last_reg;
    assign wdata_next = accept ? wdata : wdata_reg;

    assign next_is_rd = (state_next == S_RD);
    assign next_is_wr = (state_next == S_WR_SETUP) || (state_next == S_WR_PULSE) ||
                        (state_next == S_WR_HOLD);

    // Pin values are registered from the next state so every pin comes straight from a flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= S_IDLE;
            idx_reg         <= 2'd0;
            last_reg        <= 2'd0;
            cnt_reg         <= '0;
            base_reg        <= '0;
            wdata_reg       <= '0;
            ready_reg       <= 1'b0;
            resp_reg        <= 1'b0;
            rdata_reg       <= '0;
            ce_bar_reg      <= 1'b1;
            oe_bar_reg      <= 1'b1;
            we_bar_reg      <= 1'b1;
            sram_addr_reg   <= '0;
            sram_data_o_reg <= '0;
            sram_data_t_reg <= 1'b1;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            last_reg        <= last_next;
            cnt_reg         <= cnt_next;
            base_reg        <= base_next;
            wdata_reg       <= wdata_next;
            ready_reg       <= (state_next == S_IDLE);
            resp_reg        <= (state_next == S_DONE);
            ce_bar_reg      <= !(next_is_rd || next_is_wr);
            oe_bar_reg      <= !next_is_rd;
            we_bar_reg      <= (state_next != S_WR_PULSE);
            sram_data_t_reg <= !next_is_wr;
            if (next_is_rd || next_is_wr) begin
                sram_addr_reg <= base_next + {17'd0, idx_next};
            end
            if (next_is_wr) begin
                sram_data_o_reg <= wdata_next[{idx_next, 3'b000} +: 8];
            end
            if (accept) begin
                rdata_reg <= '0;
            end else if (sample) begin
                rdata_reg[{idx_reg, 3'b000} +: 8] <= sram_data_i;
            end
        end
    end

    assign ready       = ready_reg;
    assign resp        = resp_reg;
    assign rdata       = rdata_reg;
    assign sram_ce_bar = ce_bar_reg;
    assign sram_oe_bar = oe_bar_reg;
    assign sram_we_bar = we_bar_reg;
    assign sram_addr   = sram_addr_reg;
    assign sram_data_o = sram_data_o_reg;
    assign sram_data_t = sram_data_t_reg;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: behavioural SRAM model, reference memory,
// directed scenarios plus randomized traffic, and a decoupled response monitor.
module tb_sram_ctrl;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;
    localparam int MEM_SIZE = 1 << 19;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [18:0] addr = '0;
    logic [1:0]  size = '0;
    logic [31:0] wdata = '0;
    logic        ready;
    logic        resp;
    logic [31:0] rdata;
    logic        sram_ce_bar;
    logic        sram_oe_bar;
    logic        sram_we_bar;
    logic [18:0] sram_addr;
    logic [7:0]  sram_data_o;
    logic        sram_data_t;
    logic [7:0]  sram_data_i;

    always #5 clk = ~clk;

    sram_ctrl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .size(size),
        .wdata(wdata), .ready(ready), .resp(resp), .rdata(rdata),
        .sram_ce_bar(sram_ce_bar), .sram_oe_bar(sram_oe_bar), .sram_we_bar(sram_we_bar),
        .sram_addr(sram_addr), .sram_data_o(sram_data_o), .sram_data_t(sram_data_t),
        .sram_data_i(sram_data_i)
    );

    int errors = 0;
    int checks = 0;
    int cycle_cnt = 0;
    logic mon_en = 1'b0;
    logic mem_en = 1'b0;

    logic [7:0] mem [0:MEM_SIZE-1];
    logic [7:0] ref_mem [0:MEM_SIZE-1];

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
        logic        is_write;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] last_rdata = '0;
    int          last_resp_cyc = -1;
    logic        prev_we_low = 1'b0;
    logic [18:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;

    // Asynchronous SRAM: reads while CE and OE are low, latches on the rising edge of WE.
    assign sram_data_i = (!sram_ce_bar && !sram_oe_bar) ? mem[sram_addr] : 8'h00;
    always @(posedge sram_we_bar) begin
        if (mem_en && !sram_ce_bar) mem[sram_addr] = sram_data_o;
    end

    always @(posedge clk) cycle_cnt = cycle_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cycle_cnt);
        end
    endtask

    // Response monitor and pin-protocol checks.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && mon_en) begin
            if (resp) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(e.is_write ? "wr_rdata" : "rd_rdata", rdata, e.rdata);
                    check("resp_cycle", cycle_cnt, e.cyc);
                    $display("resp %s rdata=0x%08h cycle=%0d", e.is_write ? "WR" : "RD", rdata, cycle_cnt);
                end
                last_rdata    = rdata;
                last_resp_cyc = cycle_cnt;
            end else if (ready) begin
                check("rdata_hold", rdata, last_rdata);
            end
            check("no_contention", 32'(!sram_oe_bar && !sram_data_t), 32'd0);
            if (!sram_we_bar && prev_we_low) begin
                check("we_addr_stable", 32'(sram_addr), 32'(prev_addr));
                check("we_data_stable", 32'(sram_data_o), 32'(prev_data));
            end
            prev_we_low = !sram_we_bar;
            prev_addr   = sram_addr;
            prev_data   = sram_data_o;
        end else begin
            prev_we_low = 1'b0;
        end
    end

    // Drives one request, holding req until accepted, and records the reference expectation.
    task automatic issue(input logic w, input logic [18:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, output int acc);
        int n;
        int guard;
        exp_t e;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; size = sz; wdata = wd;
        guard = 0;
        while (!ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req = 1'b0;
            acc = -1;
            return;
        end
        acc = cycle_cnt;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.is_write = w;
        e.rdata = '0;
        if (w) begin
            for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % MEM_SIZE] = wd[8*i +: 8];
            e.cyc = acc + n * (WR_WAIT + 2) + 1;
        end else begin
            for (int i = 0; i < n; i++) e.rdata[8*i +: 8] = ref_mem[(int'(a) + i) % MEM_SIZE];
            e.cyc = acc + n * RD_WAIT + 1;
        end
        exp_q.push_back(e);
        $display("req %s addr=0x%05h size=%0d wdata=0x%08h accepted cycle=%0d", w ? "WR" : "RD", a, sz, wd, acc);
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || !ready) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int acc2;
        int windows;
        logic prev_we;
        logic [31:0] r;

        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end

        #2 rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_resp", 32'(resp), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_strobes", {29'd0, sram_ce_bar, sram_oe_bar, sram_we_bar}, 32'd7);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_data_o", 32'(sram_data_o), 32'd0);
        check("rst_data_t", 32'(sram_data_t), 32'd1);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(ready), 32'd1);
        mem_en = 1'b1;
        mon_en = 1'b1;

        // Word write / read with latency checks against the spec formulas.
        issue(1'b1, 19'h00010, 2'd2, 32'hDEADBEEF, acc);
        drain();
        check("word_wr_lat", 32'(last_resp_cyc - acc), 32'd17);
        check("mem_10", 32'(mem[19'h10]), 32'hEF);
        check("mem_11", 32'(mem[19'h11]), 32'hBE);
        check("mem_12", 32'(mem[19'h12]), 32'hAD);
        check("mem_13", 32'(mem[19'h13]), 32'hDE);
        issue(1'b0, 19'h00010, 2'd2, 32'h0, acc);
        drain();
        check("word_rd_lat", 32'(last_resp_cyc - acc), 32'd9);
        check("word_rd_val", last_rdata, 32'hDEADBEEF);

        // Byte write, byte read, then a word read around it to check neighbours.
        issue(1'b1, 19'h00003, 2'd0, 32'hFFFFFF5A, acc);
        issue(1'b0, 19'h00003, 2'd0, 32'h0, acc);
        drain();
        check("byte_rd_val", last_rdata, 32'h0000005A);
        issue(1'b0, 19'h00002, 2'd3, 32'h0, acc);
        drain();

        // Halfword across the top of the address space.
        issue(1'b1, 19'h7FFFF, 2'd1, 32'hABCD1234, acc);
        drain();
        check("mem_7ffff", 32'(mem[19'h7FFFF]), 32'h34);
        check("mem_00000", 32'(mem[19'h00000]), 32'h12);
        issue(1'b0, 19'h7FFFF, 2'd1, 32'h0, acc);
        drain();
        check("half_wrap_rd", last_rdata, 32'h00001234);

        // Second request held during a busy read is accepted right after resp.
        issue(1'b0, 19'h00010, 2'd2, 32'h0, acc);
        issue(1'b0, 19'h00011, 2'd0, 32'h0, acc2);
        check("b2b_accept", 32'(acc2), 32'(acc + 4 * RD_WAIT + 1 + 1));
        drain();

        // Randomized traffic confined to a scratch region.
        for (int t = 0; t < 40; t++) begin
            issue(1'($urandom_range(0, 1)), 19'h01000 + 19'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)), $urandom, acc);
        end
        drain();

        // Reset during the write pulse of byte 2 of a word write.
        issue(1'b1, 19'h40000, 2'd2, 32'h11223344, acc);
        windows = 0;
        prev_we = 1'b1;
        for (int g = 0; g < 100 && windows < 3; g++) begin
            @(negedge clk);
            if (!sram_we_bar && prev_we) windows++;
            prev_we = sram_we_bar;
        end
        check("abort_reached_pulse", 32'(windows), 32'd3);
        #1 rstn = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("abort_ce", 32'(sram_ce_bar), 32'd1);
        check("abort_we", 32'(sram_we_bar), 32'd1);
        check("abort_oe", 32'(sram_oe_bar), 32'd1);
        check("abort_data_t", 32'(sram_data_t), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_resp", 32'(resp), 32'd0);
        end
        #1 rstn = 1'b1;
        last_rdata = '0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        issue(1'b0, 19'h00010, 2'd2, 32'h0, acc);
        drain();
        check("post_abort_rd", last_rdata, 32'hDEADBEEF);

        r = 32'(exp_q.size());
        check("queue_empty", r, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Bus-side controller for the external 512K x 8 asynchronous SRAM (19-bit address, active-low CE/OE/WE, bidirectional 8-bit data).
- Accepts single byte, halfword or word requests from the system bus and splits each into 1/2/4 sequential byte accesses.
- Generates glitch-free SRAM strobes and a tri-state control for the top-level data pad.
- Configurable wait states.

Parameters:
- RD_WAIT, 2, cycles OE/CE held low per byte read before sampling (>=1)
- WR_WAIT, 2, cycles WE held low per byte write (>=1)

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- req  input  1  request strobe, sampled only when ready=1
- we  input  1  1=write, 0=read
- addr  input  19  byte address of first byte
- size  input  2  0=byte, 1=halfword, 2=word, 3=treated as word
- wdata  input  32  write data, byte i in [8i+7:8i]
- ready  output  1  idle, can accept req
- resp  output  1  one-cycle completion pulse
- rdata  output  32  read data, valid while resp=1; unread bytes zero
- sram_ce_bar  output  1  chip enable, active low
- sram_oe_bar  output  1  output enable, active low
- sram_we_bar  output  1  write enable, active low
- sram_addr  output  19  SRAM address
- sram_data_o  output  8  data to pad
- sram_data_t  output  1  pad tri-state: 1=released, 0=driven
- sram_data_i  input  8  data from pad

Behaviour:
- Reset (async, rstn=0):
  - ready=0, resp=0, rdata=0.
  - ce/oe/we_bar=1, sram_addr=0, sram_data_o=0, sram_data_t=1.
  - State IDLE, idx=0, wait counter=0.
  - ready rises the first cycle after rstn deasserts.
- All sram_* outputs, ready, resp and rdata are driven straight from flops; no combinational path from req to pins.
- Byte count N = 1, 2 or 4 from size. Byte i is at address (addr+i) mod 2^19 (wraps 0x7FFFF -> 0x00000). Little-endian; no alignment check.
- IDLE:
  - ready=1, all strobes high, sram_data_t=1.
  - On req=1: latch we/addr/size/wdata, clear rdata, idx=0, ready=0.
  - Then go to RD (read) or WR_SETUP (write).
- RD:
  - ce_bar=0, oe_bar=0, we_bar=1, sram_data_t=1, sram_addr=addr+idx.
  - Held RD_WAIT cycles. On the last cycle, sample sram_data_i into rdata[8idx+7:8idx].
  - If idx=N-1, go to DONE. Otherwise idx++ and re-enter RD with the counter reloaded; ce_bar/oe_bar stay low and the address steps.
- WR_SETUP (1 cycle):
  - ce_bar=0, oe_bar=1, we_bar=1, sram_data_t=0, sram_addr=addr+idx, sram_data_o=wdata byte idx.
- WR_PULSE (WR_WAIT cycles): as WR_SETUP but we_bar=0.
- WR_HOLD (1 cycle):
  - we_bar=1; address and data still driven.
  - If last byte, go to DONE. Otherwise idx++ and go to WR_SETUP.
- oe_bar is never low while sram_data_t=0, so there is no bus contention. Address and data never change while we_bar=0.
- DONE (1 cycle):
  - resp=1, strobes high, sram_data_t=1.
  - Go to IDLE; ready=1 the next cycle.
- Latency, counting the accept cycle as 0:
  - Read: resp in cycle N*RD_WAIT+1.
  - Write: resp in cycle N*(WR_WAIT+2)+1.
  - Back-to-back: next req accepted in the cycle after resp.
- req while ready=0 is ignored; the bus holds req until accepted.
- rdata holds its value after resp until the next read is accepted. Writes leave rdata=0.
- Reset mid-transaction: strobes go high immediately and the pad is released. No resp is issued; a partial write may remain in SRAM.

Test Plan:
- Word write 0xDEADBEEF to 0x00010, then word read at 0x00010 -> bytes EF,BE,AD,DE at 0x10..0x13; rdata=0xDEADBEEF. resp in cycle 17 (write) / 9 (read) with defaults.
- Byte write 0x5A to 0x00003, then byte read -> rdata=0x0000005A; neighbouring bytes unchanged.
- Halfword write 0x1234 at 0x7FFFF -> 0x34 at 0x7FFFF, 0x12 at 0x00000. Halfword read returns 0x00001234.
- Pad and strobe check throughout writes/reads -> never oe_bar=0 with sram_data_t=0; sram_addr/sram_data_o stable during every we_bar=0 window.
- req held high during a busy word read -> ignored until ready=1. Second request is then accepted the cycle after resp.
- rstn pulsed low during WR_PULSE of byte 2 -> immediately ce/we_bar=1, sram_data_t=1, no resp. After release, ready=1 and a new read works.
